// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants shared by the UART receive path.
//   ST_*      : receive FSM state encodings (IDLE/START/DATA/PARITY/STOP)
//   PARITY_*  : PARITY_MODE encodings, common with the transmit side
package uart_rx_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side inputs and word-side outputs of the UART receiver.
//   i_tick       : 1-cycle oversampling strobe
//   i_rx         : asynchronous serial line, idle high
//   o_data       : received word, held until the next o_valid
//   o_valid      : 1-cycle frame-complete pulse
//   o_parity_err : parity mismatch on the frame qualified by o_valid
//   o_frame_err  : a stop bit was sampled low on that frame
//   o_busy       : frame reception in progress
// master = line/tick driver and word consumer, slave = the receiver.
interface uart_rx_if #(parameter int DATA_BITS = 8);
    logic                 i_tick;
    logic                 i_rx;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_busy;

    modport master (output i_tick, i_rx,
                    input  o_data, o_valid, o_parity_err, o_frame_err, o_busy);
    modport slave  (input  i_tick, i_rx,
                    output o_data, o_valid, o_parity_err, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchroniser for the serial line plus falling-edge detect.
//   i_clk, i_rst_n : clock, async active-low reset (flops reset to 1 = idle line)
//   i_rx           : raw asynchronous line
//   o_rx           : synchronised line
//   o_fall         : previous synchronised sample 1, current 0
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx,
    output logic o_fall
);
    // [0],[1] form the synchroniser; [2] is the history bit for edge detect.
    logic [2:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '1;
        else          sync_q <= {sync_q[1:0], i_rx};
    end

    assign o_rx   = sync_q[1];
    assign o_fall = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receive engine driven by a SAMPLING_RATE x oversampling tick.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : i_tick/i_rx in; o_data/o_valid/o_parity_err/o_frame_err/o_busy out
// Detects the start edge, confirms the start bit at mid-bit, samples data
// LSB-first at mid-bit, checks optional parity and 1..2 stop bits, and emits
// one registered word + flags per frame, errors included.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int SAMPLING_RATE = 16,
    parameter int PARITY_MODE   = PARITY_NONE,
    parameter int STOP_BITS     = 1
) (
    input logic  i_clk,
    input logic  i_rst_n,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(SAMPLING_RATE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(SAMPLING_RATE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(SAMPLING_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD = (PARITY_MODE == PARITY_ODD);

    logic rx_s, rx_fall;

    uart_rx_sync u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_rx   (bus.i_rx),
        .o_rx   (rx_s),
        .o_fall (rx_fall)
    );

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;    // in-flight frame flags
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;    // registered outputs
    logic                 valid_q, valid_d;
    logic                 operr_q, operr_d;
    logic                 oferr_q, oferr_d;
    logic                 busy_q, busy_d;
    logic                 ferr_now;

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        operr_d    = operr_q;
        oferr_d    = oferr_q;
        busy_d     = busy_q;
        ferr_now   = ferr_q | ~rx_s;

        case (state_q)
            ST_IDLE: begin
                // Only a high->low transition starts a frame; a line held low never does.
                if (rx_fall) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (bus.i_tick) begin
                    if (s_cnt_q == HALF_M1) begin
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            s_cnt_d   = '0;
                            bit_idx_d = '0;
                            perr_d    = 1'b0;
                            ferr_d    = 1'b0;
                        end else begin
                            // Start bit gone by mid-bit: glitch, drop silently.
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.i_tick) begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            state_d    = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            stop_cnt_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bus.i_tick) begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_d    = '0;
                        perr_d     = (^{shreg_q, rx_s}) ^ ODD;
                        state_d    = ST_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bus.i_tick) begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_d = '0;
                        ferr_d  = ferr_now;
                        if (stop_cnt_q == LAST_STOP) begin
                            // Deliver at mid-stop; IDLE is re-entered half a bit early
                            // so a back-to-back start edge is not missed.
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            valid_d = 1'b1;
                            data_d  = shreg_q;
                            operr_d = perr_q;
                            oferr_d = ferr_now;
                        end else begin
                            stop_cnt_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            s_cnt_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            operr_q    <= 1'b0;
            oferr_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            operr_q    <= operr_d;
            oferr_q    <= oferr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = operr_q;
    assign bus.o_frame_err  = oferr_q;
    assign bus.o_busy       = busy_q;
endmodule
